conv_window_gen: RTL

Upstream feeder for the 5x5 `conv` engine. Accepts a row-major signed 8-bit pixel stream over a valid/ready handshake and buffers K-1 image rows in a line buffer. For every valid output position it presents a stable KxK window, pulses `conv_start`, and waits for `conv_done`. It then emits the 32-bit result tagged with its output coordinates.

---
 rtl/conv_window_gen_pkg.sv | 20 ++
 rtl/conv_window_gen_if.sv | 12 +
 rtl/conv_window_gen_line_buffer.sv | 29 ++
 rtl/conv_window_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared types for the conv window feeder: pixel/accumulator widths, the
// KxK window layout handed to `conv`, and the feeder FSM encoding.
package conv_window_gen_pkg;

  localparam int unsigned K     = 5;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned ACC_W = 32;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef pix_t [K-1:0]            vec_t;     // one window row, or one line-buffer column
  typedef vec_t [K-1:0]            window_t;  // [i][j], i=0 oldest row, j=0 oldest column
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    FILL,
    START,
    WAIT
  } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Row-major pixel stream with valid/ready handshake feeding the window generator.
interface conv_window_gen_if;
  import conv_window_gen_pkg::*;

  logic pix_valid;
  pix_t pix_data;
  logic pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// K-1 row line buffer: one word per image column holding that column's last
// K-1 pixels, oldest in the low slot; read combinationally with the live pixel.
module conv_window_gen_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter  int unsigned IMG_W = 32,
  localparam int unsigned CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [CW-1:0] col_i,
  input  pix_t          pix_i,
  output vec_t          col_o
);

  typedef pix_t [K-2:0] word_t;

  word_t mem_q [IMG_W];

  // Shifting the whole column word at once keeps this a single-port RAM write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[col_i] <= {pix_i, mem_q[col_i][K-2:1]};
    end
  end

  assign col_o = {pix_i, mem_q[col_i]};

endmodule

// File: rtl/conv_window_gen.sv
// Builds a sliding KxK window over a pixel stream, hands each complete window
// to `conv`, and returns the result tagged with its output coordinates.
module conv_window_gen #(
  parameter  int unsigned IMG_W = 32,
  parameter  int unsigned IMG_H = 32,
  parameter  int unsigned K     = conv_window_gen_pkg::K,
  localparam int unsigned ROW_W = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1,
  localparam int unsigned COL_W = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  conv_window_gen_if.slave             pix,
  output conv_window_gen_pkg::window_t win_data,
  output logic                         conv_start,
  input  logic                         conv_done,
  input  conv_window_gen_pkg::acc_t    conv_result,
  output logic                         out_valid,
  output conv_window_gen_pkg::acc_t    out_data,
  output logic [ROW_W-1:0]             out_row,
  output logic [COL_W-1:0]             out_col,
  output logic                         frame_done
);
  import conv_window_gen_pkg::*;

  localparam int unsigned RW      = $clog2(IMG_H);
  localparam int unsigned CW      = $clog2(IMG_W);
  localparam int unsigned ROW_MAX = IMG_H - K;
  localparam int unsigned COL_MAX = IMG_W - K;

  state_t           state_q;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  window_t          win_q;
  logic             pix_ready_q;
  logic             conv_start_q;
  logic             out_valid_q;
  logic             frame_done_q;
  acc_t             out_data_q;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;
  vec_t             lb_col;
  logic             accept;
  logic             win_complete;

  assign accept       = pix.pix_valid && pix_ready_q;
  assign win_complete = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q + 1'b1;
    if (col_q == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
    end
  end

  conv_window_gen_line_buffer #(
    .IMG_W (IMG_W)
  ) u_lb (
    .clk   (clk),
    .we_i  (accept),
    .col_i (col_q),
    .pix_i (pix.pix_data),
    .col_o (lb_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      pix_ready_q  <= 1'b1;
      conv_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (accept) begin
            row_q <= row_d;
            col_q <= col_d;
            for (int unsigned i = 0; i < K; i++) begin
              win_q[i] <= {lb_col[i], win_q[i][K-1:1]};
            end
            if (win_complete) begin
              state_q      <= START;
              pix_ready_q  <= 1'b0;
              conv_start_q <= 1'b1;
              out_row_q    <= ROW_W'(row_q - RW'(K - 1));
              out_col_q    <= COL_W'(col_q - CW'(K - 1));
            end
          end
        end
        START: begin
          conv_start_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (conv_done) begin
            out_data_q   <= conv_result;
            out_valid_q  <= 1'b1;
            frame_done_q <= (out_row_q == ROW_W'(ROW_MAX)) && (out_col_q == COL_W'(COL_MAX));
            pix_ready_q  <= 1'b1;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign pix.pix_ready = pix_ready_q;
  assign win_data      = win_q;
  assign conv_start    = conv_start_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_row       = out_row_q;
  assign out_col       = out_col_q;
  assign frame_done    = frame_done_q;

endmodule
